second_order_iir_notch_filter: RTL and testbench

- Fixed-point, direct-form-I, second-order IIR notch filter; one input sample and one output sample per clock.
- Computes y[n] = B0·x[n] + B1·x[n-1] + B2·x[n-2] − A1·y[n-1] − A2·y[n-2].
- Coefficients are Q2.COEF_FRAC integers set at elaboration.
- Sits in the noise-shaping path of the DEM-DAC datapath:
  - The wide output y_out_o feeds downstream loop arithmetic.
  - The saturated WIDTH-bit copy ntf_out_o feeds the next stage.
  - The four state registers are exported for observability.

---
 rtl/second_order_iir_notch_filter.sv | 117 +++++++++++
 tb/tb_second_order_iir_notch_filter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/second_order_iir_notch_filter.sv
// Direct-form-I second-order IIR notch filter, one sample per clock.
// Full-precision accumulate, floor scaling, saturation to the state width and to WIDTH bits.
module second_order_iir_notch_filter #(
    parameter int WIDTH     = 16,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 14,
    parameter logic signed [COEF_W-1:0] B0 = COEF_W'(16384),
    parameter logic signed [COEF_W-1:0] B1 = COEF_W'(0),
    parameter logic signed [COEF_W-1:0] B2 = COEF_W'(16384),
    parameter logic signed [COEF_W-1:0] A1 = COEF_W'(0),
    parameter logic signed [COEF_W-1:0] A2 = COEF_W'(12288)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic signed [WIDTH-1:0]     x_in_i,
    output logic signed [4*WIDTH-1:0]   y_out_o,
    output logic signed [WIDTH-1:0]     ntf_out_o,
    output logic signed [4*WIDTH-1:0]   x_prev1_o,
    output logic signed [4*WIDTH-1:0]   x_prev2_o,
    output logic signed [4*WIDTH-1:0]   y_prev1_o,
    output logic signed [4*WIDTH-1:0]   y_prev2_o
);

    localparam int YW    = 4 * WIDTH;
    localparam int ACC_W = YW + COEF_W + 3;

    // Coefficients sign-extended once so every product is formed at accumulator width.
    localparam logic signed [ACC_W-1:0] B0_E = ACC_W'(B0);
    localparam logic signed [ACC_W-1:0] B1_E = ACC_W'(B1);
    localparam logic signed [ACC_W-1:0] B2_E = ACC_W'(B2);
    localparam logic signed [ACC_W-1:0] A1_E = ACC_W'(A1);
    localparam logic signed [ACC_W-1:0] A2_E = ACC_W'(A2);

    localparam logic signed [ACC_W-1:0] Y_MAX =
        signed'({{(ACC_W-YW+1){1'b0}}, {(YW-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] Y_MIN =
        signed'({{(ACC_W-YW+1){1'b1}}, {(YW-1){1'b0}}});
    localparam logic signed [YW-1:0] N_MAX =
        signed'({{(YW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
    localparam logic signed [YW-1:0] N_MIN =
        signed'({{(YW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});

    logic signed [YW-1:0]    x_prev1;
    logic signed [YW-1:0]    x_prev2;
    logic signed [YW-1:0]    y_prev1;
    logic signed [YW-1:0]    y_prev2;
    logic signed [YW-1:0]    y_reg;
    logic signed [WIDTH-1:0] ntf_reg;

    logic signed [ACC_W-1:0] x0_e;
    logic signed [ACC_W-1:0] x1_e;
    logic signed [ACC_W-1:0] x2_e;
    logic signed [ACC_W-1:0] y1_e;
    logic signed [ACC_W-1:0] y2_e;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] y_shift;
    logic signed [YW-1:0]    y_sat;
    logic signed [WIDTH-1:0] ntf_new;
    logic signed [YW-1:0]    x_in_ext;

    assign x_in_ext = YW'(x_in_i);
    assign x0_e     = ACC_W'(x_in_i);
    assign x1_e     = ACC_W'(x_prev1);
    assign x2_e     = ACC_W'(x_prev2);
    assign y1_e     = ACC_W'(y_prev1);
    assign y2_e     = ACC_W'(y_prev2);

    assign acc = B0_E * x0_e + B1_E * x1_e + B2_E * x2_e
               - A1_E * y1_e - A2_E * y2_e;

    // Arithmetic shift gives floor rounding (toward minus infinity).
    assign y_shift = acc >>> COEF_FRAC;

    always_comb begin
        y_sat = YW'(y_shift);
        if (y_shift > Y_MAX) begin
            y_sat = Y_MAX[YW-1:0];
        end else if (y_shift < Y_MIN) begin
            y_sat = Y_MIN[YW-1:0];
        end
    end

    always_comb begin
        ntf_new = WIDTH'(y_sat);
        if (y_sat > N_MAX) begin
            ntf_new = N_MAX[WIDTH-1:0];
        end else if (y_sat < N_MIN) begin
            ntf_new = N_MIN[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            x_prev1 <= '0;
            x_prev2 <= '0;
            y_prev1 <= '0;
            y_prev2 <= '0;
            y_reg   <= '0;
            ntf_reg <= '0;
        end else begin
            x_prev1 <= x_in_ext;
            x_prev2 <= x_prev1;
            y_prev1 <= y_sat;
            y_prev2 <= y_prev1;
            y_reg   <= y_sat;
            ntf_reg <= ntf_new;
        end
    end

    assign y_out_o   = y_reg;
    assign ntf_out_o = ntf_reg;
    assign x_prev1_o = x_prev1;
    assign x_prev2_o = x_prev2;
    assign y_prev1_o = y_prev1;
    assign y_prev2_o = y_prev2;

endmodule

// File: tb/tb_second_order_iir_notch_filter.sv
// Directed-vector bench for the notch filter: driver pushes hand-computed results,
// a monitor pops and compares them one cycle after each sample is taken.
module tb_second_order_iir_notch_filter;

    localparam int W  = 16;
    localparam int YW = 64;

    typedef struct packed {
        logic [YW-1:0] y;
        logic [W-1:0]  ntf;
        logic [YW-1:0] xp1;
        logic [YW-1:0] xp2;
        logic [YW-1:0] yp2;
    } exp_t;

    logic                 clk_i = 1'b0;
    logic                 reset_i = 1'b0;
    logic signed [W-1:0]  x_in_i = '0;
    logic signed [YW-1:0] y_out_o;
    logic signed [W-1:0]  ntf_out_o;
    logic signed [YW-1:0] x_prev1_o;
    logic signed [YW-1:0] x_prev2_o;
    logic signed [YW-1:0] y_prev1_o;
    logic signed [YW-1:0] y_prev2_o;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic signed [YW-1:0] hx1 = '0;
    logic signed [YW-1:0] hy1 = '0;

    second_order_iir_notch_filter dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .x_in_i    (x_in_i),
        .y_out_o   (y_out_o),
        .ntf_out_o (ntf_out_o),
        .x_prev1_o (x_prev1_o),
        .x_prev2_o (x_prev2_o),
        .y_prev1_o (y_prev1_o),
        .y_prev2_o (y_prev2_o)
    );

    // Clock and reset
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic signed [YW-1:0] act,
                         input logic signed [YW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Driver: one sample per cycle, expected results pushed at issue time.
    task automatic vec(input logic rst_n, input int x, input longint y, input int ntf);
        exp_t e;
        @(negedge clk_i);
        reset_i = rst_n;
        x_in_i  = W'(x);
        if (!rst_n) begin
            e   = '0;
            hx1 = '0;
            hy1 = '0;
        end else begin
            e.y   = YW'(y);
            e.ntf = W'(ntf);
            e.xp1 = YW'(x);
            e.xp2 = hx1;
            e.yp2 = hy1;
            hx1   = YW'(x);
            hy1   = YW'(y);
        end
        exp_q.push_back(e);
    endtask

    task automatic run(input int xs[], input longint ys[], input int ns[]);
        for (int i = 0; i < xs.size(); i++) begin
            vec(1'b1, xs[i], ys[i], ns[i]);
        end
    endtask

    // Monitor / scoreboard
    always begin
        exp_t e;
        @(posedge clk_i);
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("y_out",   y_out_o,        signed'(e.y));
            check("ntf_out", YW'(ntf_out_o), YW'(signed'(e.ntf)));
            check("x_prev1", x_prev1_o,      signed'(e.xp1));
            check("x_prev2", x_prev2_o,      signed'(e.xp2));
            check("y_prev1", y_prev1_o,      signed'(e.y));
            check("y_prev2", y_prev2_o,      signed'(e.yp2));
        end
    end

    initial begin
        // Reset held two cycles with nonzero input, then released with zero input
        vec(1'b0, 1234, 0, 0);
        vec(1'b0, -77, 0, 0);
        vec(1'b1, 0, 0, 0);
        vec(1'b1, 0, 0, 0);

        // Step of 50, then reset mid-stream and restart
        vec(1'b0, 50, 0, 0);
        run('{50, 50, 50, 50, 50, 50}, '{50, 50, 62, 62, 53, 53}, '{50, 50, 62, 62, 53, 53});
        vec(1'b0, 50, 0, 0);
        run('{50, 50, 50}, '{50, 50, 62}, '{50, 50, 62});

        // Tone at fs/4 is notched out; response decays
        vec(1'b0, 0, 0, 0);
        run('{100, 0, -100, 0, 100, 0, -100, 0, 100},
            '{100, 0, -75, 0, 56, 0, -42, 0, 31},
            '{100, 0, -75, 0, 56, 0, -42, 0, 31});

        // Negative impulse: -150 + 112.5 = -37.5 floors to -38, then 28.5 floors to 28
        vec(1'b0, 0, 0, 0);
        run('{-150, 0, 0, 0, 0}, '{-150, 0, -38, 0, 28}, '{-150, 0, -38, 0, 28});

        // Positive and negative full-scale steps saturate the narrow output
        vec(1'b0, 0, 0, 0);
        run('{32767, 32767, 32767}, '{32767, 32767, 40958}, '{32767, 32767, 32767});
        vec(1'b0, 0, 0, 0);
        run('{-32768, -32768, -32768}, '{-32768, -32768, -40960}, '{-32768, -32768, -32768});

        repeat (3) @(negedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
